serial_chunk_adder: RTL and testbench

//   Multi-cycle parametrised adder. Adds WIDTH-bit operands SLICE_W bits per clock,

---
 rtl/serial_add_pkg.sv | 15 +
 rtl/add_slice.sv | 23 ++
 rtl/serial_chunk_adder.sv | 118 +++++++++++
 tb/tb_serial_chunk_adder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared state encoding and counter-width helper for serial_chunk_adder
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slice counter width; a single-slice adder still gets a 1-bit counter.
    function automatic int cnt_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/add_slice.sv
// rtl/add_slice.sv - combinational W-bit slice adder exposing carry-out and carry into its MSB
module add_slice #(
    parameter int W = 2
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);

    logic [W:0] full;

    // One extra bit holds the carry out; the carry into the MSB is recovered from the MSB sum bit.
    always_comb begin
        full  = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
        s     = full[W-1:0];
        co    = full[W];
        c_msb = full[W-1] ^ x[W-1] ^ y[W-1];
    end

endmodule

// File: rtl/serial_chunk_adder.sv
// rtl/serial_chunk_adder.sv - multi-cycle slice-serial adder with start/busy/done; SUBTRACT_EN adds the sub port
module serial_chunk_adder
    import serial_add_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SLICE_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / SLICE_W;
    localparam int CNT_W  = cnt_width(NCHUNK);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   psum;
    logic [WIDTH-1:0]   psum_next;
    logic               carry;
    logic [SLICE_W-1:0] s_slice;
    logic               co_slice;
    logic               cmsb_slice;
    logic               b_inv;
    logic               c_init;

    // Subtraction is a + ~b + 1, so it only changes how b and the initial carry are loaded.
    always_comb begin
`ifdef SUBTRACT_EN
        b_inv  = sub;
        c_init = sub | cin;
`else
        b_inv  = 1'b0;
        c_init = cin;
`endif
    end

    add_slice #(.W(SLICE_W)) u_slice (
        .x     (a_sh[SLICE_W-1:0]),
        .y     (b_sh[SLICE_W-1:0]),
        .ci    (carry),
        .s     (s_slice),
        .co    (co_slice),
        .c_msb (cmsb_slice)
    );

    // Each slice result enters at the top so the LS slice ends at bit 0 after NCHUNK shifts.
    assign psum_next = (psum >> SLICE_W) | (WIDTH'(s_slice) << (WIDTH - SLICE_W));

    // Control FSM plus datapath registers; results only move on the DONE-entry edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_inv ? ~b : b;
                        carry <= c_init;
                        cnt   <= '0;
                        psum  <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> SLICE_W;
                    b_sh  <= b_sh >> SLICE_W;
                    carry <= co_slice;
                    psum  <= psum_next;
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= psum_next;
                        cout  <= co_slice;
                        ovf   <= co_slice ^ cmsb_slice;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb/tb_serial_chunk_adder.sv - directed scoreboard bench for serial_chunk_adder (WIDTH=8, SLICE_W=2)
module tb_serial_chunk_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cin = 1'b0;
    logic       sub = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;

    serial_chunk_adder #(.WIDTH(8), .SLICE_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SUBTRACT_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                   input logic ci, input logic sb);
        logic [7:0] yy;
        logic       c;
        logic [8:0] r;
        exp_t       e;
        yy     = sb ? ~y : y;
        c      = sb ? 1'b1 : ci;
        r      = {1'b0, x} + {1'b0, yy} + 9'(c);
        e.sum  = r[7:0];
        e.cout = r[8];
        e.ovf  = (x[7] == yy[7]) && (r[7] != x[7]);
        return e;
    endfunction

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_cnt++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_done observed=1 expected=0");
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sum", 32'(sum), 32'(e.sum));
                chk("cout", 32'(cout), 32'(e.cout));
                chk("ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    // Call just after a negedge: drives a request that is accepted on the next rising edge.
    task automatic launch(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic sb);
        a     = x;
        b     = y;
        cin   = ci;
        sub   = sb;
        start = 1'b1;
        exp_q.push_back(model(x, y, ci, sb));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = done_cnt;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            if (done_cnt != n) break;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt != n), 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                         input logic ci, input logic sb);
        @(negedge clk);
        launch(x, y, ci, sb);
        wait_done(tag);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;

        // 1: latency, busy/done timing, result stability during RUN
        @(negedge clk);
        launch(8'h0F, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_busy_run", 32'(busy), 32'd1);
            chk("t1_done_run", 32'(done), 32'd0);
            chk("t1_sum_stable", 32'(sum), 32'd0);
        end
        @(negedge clk);
        chk("t1_done_pulse", 32'(done), 32'd1);
        chk("t1_busy_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t1_done_drop", 32'(done), 32'd0);
        chk("t1_sum_hold", 32'(sum), 32'h10);

        // 2, 3: carry and overflow boundaries
        do_op("t2a", 8'hFF, 8'h01, 1'b0, 1'b0);
        do_op("t2b", 8'hFF, 8'h00, 1'b1, 1'b0);
        do_op("t3a", 8'h7F, 8'h01, 1'b0, 1'b0);
        do_op("t3b", 8'h80, 8'h80, 1'b0, 1'b0);
        do_op("t3c", 8'hA5, 8'h3C, 1'b1, 1'b0);

        // 4: start during RUN ignored, start held at DONE chains without idle
        @(negedge clk);
        launch(8'h12, 8'h34, 1'b0, 1'b0);
        @(negedge clk);
        a = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        b = 8'h77;
        @(negedge clk);
        @(negedge clk);
        a = 8'h01;
        b = 8'h02;
        cin = 1'b0;
        start = 1'b1;
        exp_q.push_back(model(8'h01, 8'h02, 1'b0, 1'b0));
        @(negedge clk);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_sum_first", 32'(sum), 32'h46);
        @(negedge clk);
        start = 1'b0;
        chk("t4_busy_chain", 32'(busy), 32'd1);
        wait_done("t4b");

        // 5: asynchronous reset mid-RUN aborts the operation
        @(negedge clk);
        launch(8'h55, 8'h22, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_sum", 32'(sum), 32'd0);
        chk("t5_cout", 32'(cout), 32'd0);
        exp_q.delete();
        n = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("t5_no_done", 32'(done_cnt), 32'(n));
        do_op("t5_fresh", 8'h3C, 8'h0F, 1'b1, 1'b0);

`ifdef SUBTRACT_EN
        // 6: subtraction
        do_op("t6a", 8'h05, 8'h07, 1'b0, 1'b1);
        do_op("t6b", 8'h80, 8'h01, 1'b1, 1'b1);
        do_op("t6c", 8'h40, 8'h40, 1'b0, 1'b1);
`endif

        repeat (2) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
